// File: rtl/snn_config_loader.sv
// snn_config_loader
//   Byte-serial configuration writer for the delayed-spike SNN core.
//   Framed bytes (SYNC, ADDR, LEN, LEN data bytes [, CHK]) arrive on a
//   valid/ready stream. Each frame lands in a shadow image and is copied
//   to the active image in one cycle, so the network never observes a
//   half-written configuration.
//
//   Optional feature macro: CFG_CHECKSUM_EN
//     defined   -> frames carry a trailing XOR checksum byte (CHK state)
//     undefined -> frame ends at the last data byte, no checksum logic
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    input byte stream
//   in_ready            low only during the commit cycle
//   weights             active bytes 0..47  (byte k at [k*8 +: 8])
//   delays              active bytes 48..71 (byte k at [k*8 +: 8])
//   threshold/decay/refractory_period  active bytes 72/73/74
//   cfg_update          one-cycle pulse when the active image changes
//   cfg_error           one-cycle pulse when a frame is aborted
//   cfg_loaded          sticky, set by the first successful commit
module snn_config_loader #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [383:0] weights,
  output logic [191:0] delays,
  output logic [7:0]   threshold,
  output logic [7:0]   decay,
  output logic [7:0]   refractory_period,
  output logic         cfg_update,
  output logic         cfg_error,
  output logic         cfg_loaded
);

  localparam int NBYTES = 75;
  localparam int GW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
`ifdef CFG_CHECKSUM_EN
    S_CHK,
`endif
    S_COMMIT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [6:0]      ptr_q, ptr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      shadow_q [NBYTES];
  logic [7:0]      shadow_d [NBYTES];
  logic [7:0]      active_q [NBYTES];
  logic [7:0]      active_d [NBYTES];
  logic            in_ready_q, in_ready_d;
  logic            update_q, update_d;
  logic            error_q, error_d;
  logic            loaded_q, loaded_d;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  logic            xfer;
  logic            in_frame;
  logic [8:0]      end_addr;
  logic [GW-1:0]   gap_inc;

  assign xfer     = in_valid & in_ready_q;
  // 9-bit sum so that large ADDR/LEN values cannot wrap into range
  assign end_addr = {1'b0, addr_q} + {1'b0, in_data};
  assign gap_inc  = gap_q + 1'b1;

  always_comb begin
    in_frame = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_DATA);
`ifdef CFG_CHECKSUM_EN
    if (state_q == S_CHK) in_frame = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gap_d    = '0;
    shadow_d = shadow_q;
    active_d = active_q;
    update_d = 1'b0;
    error_d  = 1'b0;
    loaded_d = loaded_q;
`ifdef CFG_CHECKSUM_EN
    chk_d    = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (xfer && (in_data == SYNC)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (xfer) begin
          addr_d   = in_data;
          // Start from the active image so unwritten bytes keep their value
          shadow_d = active_q;
`ifdef CFG_CHECKSUM_EN
          chk_d    = in_data;
`endif
          state_d  = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
`ifdef CFG_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          if ((in_data == 8'd0) || (end_addr > 9'(NBYTES))) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = in_data;
            ptr_d   = addr_q[6:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shadow_d[ptr_q] = in_data;
          ptr_d           = ptr_q + 7'd1;
          cnt_d           = cnt_q - 8'd1;
`ifdef CFG_CHECKSUM_EN
          chk_d           = chk_q ^ in_data;
          if (cnt_q == 8'd1) state_d = S_CHK;
`else
          if (cnt_q == 8'd1) state_d = S_COMMIT;
`endif
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (in_data == chk_q) begin
            state_d = S_COMMIT;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_COMMIT: begin
        active_d = shadow_q;
        update_d = 1'b1;
        loaded_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte gap watchdog; a transfer or leaving the frame clears it
    if (in_frame && !xfer && (TIMEOUT != 0)) begin
      if (gap_inc == GW'(TIMEOUT)) begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        gap_d = gap_inc;
      end
    end
  end

  // Registered ready: low exactly while the commit cycle is in progress
  assign in_ready_d = (state_d != S_COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gap_q      <= '0;
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
      in_ready_q <= 1'b1;
      update_q   <= 1'b0;
      error_q    <= 1'b0;
      loaded_q   <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      in_ready_q <= in_ready_d;
      update_q   <= update_d;
      error_q    <= error_d;
      loaded_q   <= loaded_d;
`ifdef CFG_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 48; gi++) begin : g_weights
      assign weights[gi*8 +: 8] = active_q[gi];
    end
    for (gi = 0; gi < 24; gi++) begin : g_delays
      assign delays[gi*8 +: 8] = active_q[48 + gi];
    end
  endgenerate

  assign threshold         = active_q[72];
  assign decay             = active_q[73];
  assign refractory_period = active_q[74];
  assign in_ready          = in_ready_q;
  assign cfg_update        = update_q;
  assign cfg_error         = error_q;
  assign cfg_loaded        = loaded_q;

endmodule

// File: doc/snn_config_loader.md
# snn_config_loader

Byte-serial configuration writer for the delayed-spike SNN core: accepts framed bytes over a valid/ready stream and writes the flat parameter buses the network top consumes (48 weight bytes, 24 packed delay bytes, threshold, decay, refractory period). Frames land in a shadow image and are committed atomically to the active outputs, so a running network never sees a half-written configuration. It sits between the chip's input pins/host bridge and the network top.

## Interface
- `TIMEOUT`, default 255: idle cycles allowed between bytes inside a frame before abort; 0 disables.
- `SYNC`, default 8'hA5: frame start byte.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: byte present.
- `in_ready` output 1: loader can accept; a byte transfers when `in_valid & in_ready` at the rising `clk` edge.
- `weights` output 384: active weights; byte k at `[k*8 +: 8]`.
- `delays` output 192: active packed delays, 4 bits per synapse; byte k at `[k*8 +: 8]`.
- `threshold`, `decay`, `refractory_period` output 8 each: active scalars.
- `cfg_update` output 1: one-cycle pulse when the active image changes.
- `cfg_error` output 1: one-cycle pulse on an aborted frame.
- `cfg_loaded` output 1: sticky, high after the first successful commit.

## Operation
- Byte address map (0..74): 0–47 weights, 48–71 delays, 72 threshold, 73 decay, 74 refractory_period.
- Frame: `SYNC`, `ADDR`, `LEN`, `LEN` data bytes, `CHK` (CHK only with macro).
- States: IDLE, ADDR, LEN, DATA, CHK, COMMIT.
- IDLE: discard bytes until `SYNC`, then go to ADDR. A `SYNC` value inside a payload has no special meaning.
- ADDR: latch the start address. Copy the active image into the shadow in the same cycle.
- LEN: if `LEN == 0` or `ADDR + LEN > 75` (9-bit sum), pulse `cfg_error` and return to IDLE. Otherwise load the byte counter with `LEN`.
- DATA: write each byte to `shadow[ptr]`, increment `ptr`, and decrement the counter. On the last byte, go to CHK (or to COMMIT without the macro).
- CHK: running XOR of ADDR, LEN and all data bytes. If the checksum byte is equal, go to COMMIT. If it differs, pulse `cfg_error`, discard the shadow and go to IDLE.
- COMMIT: copy shadow to active, pulse `cfg_update`, set `cfg_loaded`, then go to IDLE.
- Timeout: in ADDR, LEN, DATA or CHK, a cycle without a transfer increments the gap counter and a transfer clears it. When the counter reaches `TIMEOUT`, pulse `cfg_error` and go to IDLE.
- Bytes outside the written range keep their previous active value.

## Timing
- Reset values:
  - `in_ready` = 1.
  - All active and shadow registers = 0.
  - `cfg_update`, `cfg_error` and `cfg_loaded` = 0.
  - State = IDLE.
- `in_ready` is 0 only in the COMMIT cycle.
- The active image and `cfg_update` change on the edge that ends the COMMIT cycle. This is 2 cycles after the final byte is accepted.
- `cfg_error` asserts the cycle after the offending byte is accepted, or the cycle after the timeout is reached.
- Back-to-back frames: a `SYNC` byte may be accepted in the cycle after COMMIT.
- A reset asserted mid-frame clears everything, including active outputs, immediately and asynchronously.

## Configuration
- `CFG_CHECKSUM_EN` defined: the CHK state and XOR check are present, and frames need a trailing checksum byte.
- Macro undefined: there is no CHK state, the frame ends at the last data byte and goes straight to COMMIT, and the XOR logic is removed. The only remaining error sources are an invalid LEN and timeout.

## Test plan
- Full load, macro on: A5, 00, 4B, bytes 0x01..0x4B, then the XOR byte. Required result: `weights[7:0]`=01, `delays[7:0]`=31, `threshold`=49, `decay`=4A, `refractory_period`=4B. `cfg_update` pulses once, 2 cycles after the checksum byte, and `cfg_loaded`=1.
- Partial write: after the full load, send A5, 48, 01, 0F, checksum 0x46. Required result: only `threshold`=0F changes, and all other outputs are unchanged.
- Bad checksum: send A5, 48, 01, 0F, 00. Required result: `cfg_error` pulses, `cfg_update` stays 0, and `threshold` is unchanged.
- Range error: send A5, 4A, 02. Required result: `cfg_error` pulses after the LEN byte, the next byte 0x55 is ignored in IDLE, and the outputs are unchanged.
- Timeout: with `TIMEOUT`=4, send A5, 00, 02, 11, then hold `in_valid` low for 4 cycles. Required result: `cfg_error` pulses, and a following valid frame commits normally.
- Reset mid-frame: assert `rst_n` low during DATA. Required result: all outputs are 0 immediately and `in_ready`=1 after release.
